ready_serializer: RTL
=====================

Name: ready_serializer

Overview:
- Ready/valid transmitter stage: accepts one wide word (WIDTH*RATIO bits) per handshake and emits it as RATIO narrow beats on a ready/valid output stream.
- Sits at the sending end of a narrow ready/valid link, e.g. between a wide datapath and a pipeline stage or narrow sink.
- Output data and valid are registered; full throughput of one beat per clock, with no bubble between consecutive words.

Parameters:
- WIDTH, 16, output beat width in bits.
- RATIO, 4, beats per input word; legal values are 1 to 2^CNT_W.
- CNT_W, 2, beat counter width; must satisfy 2^CNT_W >= RATIO; minimum 1.

Ports:
- clk  input  1  clock.
- arst  input  1  reset, asynchronous, active-high.
- valid_i  input  1  source word valid.
- dat_i  input  WIDTH*RATIO  source word; slice k is dat_i[k*WIDTH +: WIDTH].
- ready_i  output  1  block can accept a word this cycle; combinational.
- valid_o  output  1  beat valid; registered.
- dat_o  output  WIDTH  beat data; registered.
- last_o  output  1  current beat is the final beat of its word; registered; qualified by valid_o.
- ready_o  input  1  sink accepts the beat.

Behaviour:
- Internal state: word hold register hold (WIDTH*RATIO bits) and beat counter cnt (CNT_W bits).
- States:
  - IDLE: valid_o = 0.
  - SEND: valid_o = 1.
- ready_i = !valid_o | (ready_o & last_o). No other combinational path from ready_o exists.
- Input accept = valid_i & ready_i. Beat accept = valid_o & ready_o.
- On input accept:
  - hold <= dat_i; cnt <= 0; valid_o <= 1.
  - dat_o <= slice 0 of dat_i; last_o <= (RATIO == 1).
  - Latency from input accept to first beat valid is 1 cycle.
- On beat accept with last_o = 0:
  - cnt <= cnt + 1; dat_o <= slice cnt+1 of hold; last_o <= (cnt+1 == RATIO-1).
  - Counter never reaches or wraps past RATIO-1 within a word.
- On beat accept with last_o = 1:
  - If valid_i = 1, the next word is accepted in the same cycle (ready_i = 1). Its slice 0 appears on the next cycle with zero bubble.
  - If valid_i = 0, go to IDLE: valid_o <= 0, last_o <= 0. dat_o holds its last value.
- Stall (valid_o = 1, ready_o = 0): valid_o, dat_o, last_o and cnt are all held stable, and ready_i = 0.
- valid_o never drops without a beat accept.
- Source obligation: dat_i need only be stable in the accept cycle. After acceptance the word is copied into hold, so dat_i is free to change.
- Steady-state throughput: one word per RATIO cycles when ready_o is held at 1.
- RATIO = 1: behaves as a single registered stage with last_o = 1 on every beat. Back-to-back words give 1 word per cycle.
- Reset values: valid_o = 0, dat_o = 0, last_o = 0, cnt = 0, hold = 0, which gives ready_i = 1.
- Reset asserted mid-word: any partially sent word is discarded, with no resumption after reset release. The first cycle after release is IDLE.

Optional Feature:
- Macro READY_SER_MSB_FIRST_EN.
  - Defined: beat order is reversed. Beat k carries slice RATIO-1-k, so the most-significant slice goes first and last_o is set on slice 0.
  - Undefined (default): least-significant slice first, beat k carries slice k.
- All handshake timing is identical in both builds.

Test Plan (WIDTH=8, RATIO=4, CNT_W=2 unless stated):
- Single word: dat_i=32'hDDCCBBAA accepted with ready_o=1 throughout -> dat_o AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept. last_o is high only with DD. valid_o drops the next cycle, and ready_i is 0 during AA..CC.
- Back-to-back: words 32'h44332211 and 32'h88776655 presented continuously -> 8 contiguous beats 11..44,55..88 with no valid_o gap. The second word is accepted in the same cycle that beat 44 is accepted.
- Stall: ready_o=0 for 3 cycles while BB is shown -> valid_o=1, dat_o=BB, last_o=0, ready_i=0 held all 3 cycles. CC follows the cycle after ready_o returns to 1.
- Reset mid-word: assert arst after beat BB -> valid_o=0, dat_o=00, last_o=0, ready_i=1 immediately. After release, new word 32'h0A0B0C0D emits 0D,0C,0B,0A with no leftover CC or DD.
- RATIO=1, WIDTH=8: values 01,02,03 sent with ready_o=1 -> dat_o 01,02,03 on consecutive cycles with last_o=1 each. A ready_o=0 cycle holds 02 with ready_i=0.
- READY_SER_MSB_FIRST_EN defined: dat_i=32'hDDCCBBAA -> beats DD,CC,BB,AA, last_o high with AA, same cycle timing as the first scenario.

Source files
------------

// File: rtl/ready_serializer.sv
// Wide-to-narrow ready/valid serializer: one WIDTH*RATIO word in, RATIO WIDTH-bit beats out.
// Optional READY_SER_MSB_FIRST_EN sends the most-significant slice first.
module ready_serializer #(
    parameter int WIDTH = 16,
    parameter int RATIO = 4,
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   valid_i,
    input  logic [WIDTH*RATIO-1:0] dat_i,
    output logic                   ready_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       dat_o,
    output logic                   last_o,
    input  logic                   ready_o
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [WIDTH*RATIO-1:0] hold;
    logic [CNT_W-1:0]       cnt;
    logic                   in_acc;
    logic                   beat_acc;
    int                     nxt;

    // Map beat number to slice; out-of-range numbers fall back to slice 0
    // and are never actually registered.
    function automatic logic [WIDTH-1:0] beat(input logic [WIDTH*RATIO-1:0] w, input int k);
        int s;
`ifdef READY_SER_MSB_FIRST_EN
        s = RATIO - 1 - k;
`else
        s = k;
`endif
        if (s < 0 || s >= RATIO) s = 0;
        return w[s*WIDTH +: WIDTH];
    endfunction

    assign valid_o  = (state == SEND);
    assign ready_i  = !valid_o | (ready_o & last_o);
    assign in_acc   = valid_i & ready_i;
    assign beat_acc = valid_o & ready_o;
    assign nxt      = int'(cnt) + 1;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            hold   <= '0;
            cnt    <= '0;
            dat_o  <= '0;
            last_o <= 1'b0;
        end else if (in_acc) begin
            // Covers both the idle case and the zero-bubble reload on the last beat.
            state  <= SEND;
            hold   <= dat_i;
            cnt    <= '0;
            dat_o  <= beat(dat_i, 0);
            last_o <= (RATIO == 1);
        end else if (beat_acc) begin
            if (last_o) begin
                state  <= IDLE;
                last_o <= 1'b0;
            end else begin
                cnt    <= cnt + 1'b1;
                dat_o  <= beat(hold, nxt);
                last_o <= (nxt == RATIO - 1);
            end
        end
    end

endmodule
